// File: rtl/kernel_window_buffer.sv
// kernel_window_buffer
//   Streams raster-order pixels and builds a KERNEL_W x KERNEL_W sliding
//   window in valid-only mode, so no padding is applied. KERNEL_W-1 circular
//   line memories hold the previous lines. A register window shifts one
//   column per accepted pixel.
//
// Ports
//   clk_i          : clock, rising edge
//   srst_i         : synchronous active-high reset
//   data_i         : pixel in raster order
//   valid_i        : data_i is accepted on every edge where valid_i=1
//   sof_i          : start of frame, qualified by valid_i
//   window_o       : element (r,c) at [(r*KERNEL_W+c)*DATA_W +: DATA_W]
//                    r=0 is the oldest line, c=0 is the oldest column
//   window_valid_o : window_o holds a complete window (1-cycle pulse)
//   eol_o          : the window is the last one of its line
//   eof_o          : the window is the last one of the frame
module kernel_window_buffer #(
  parameter int DATA_W   = 8,
  parameter int KERNEL_W = 3,
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 512
) (
  input  logic                                 clk_i,
  input  logic                                 srst_i,
  input  logic [DATA_W-1:0]                    data_i,
  input  logic                                 valid_i,
  input  logic                                 sof_i,
  output logic [KERNEL_W*KERNEL_W*DATA_W-1:0]  window_o,
  output logic                                 window_valid_o,
  output logic                                 eol_o,
  output logic                                 eof_o
);

  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H);
  localparam int NL       = KERNEL_W - 1;
  localparam int WIN_BITS = KERNEL_W * KERNEL_W * DATA_W;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(KERNEL_W - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(KERNEL_W - 1);

  logic [COL_W-1:0] col_reg, col_next, col_cur;
  logic [ROW_W-1:0] row_reg, row_next, row_cur;
  logic             accept;
  logic             win_done;
  logic             at_eol;
  logic             at_eof;

  logic [DATA_W-1:0] win_reg  [KERNEL_W][KERNEL_W];
  logic [DATA_W-1:0] win_next [KERNEL_W][KERNEL_W];
  logic [WIN_BITS-1:0] win_flat;

  // rd_data[k] holds line row-NL+k at address col_cur. k=NL-1 is the newest line.
  logic [NL-1:0][DATA_W-1:0] rd_data;

  // A pixel that carries sof_i is treated as (0,0), whatever the counters hold.
  always_comb begin
    accept   = valid_i && !srst_i;
    col_cur  = sof_i ? '0 : col_reg;
    row_cur  = sof_i ? '0 : row_reg;
    win_done = (row_cur >= ROW_FIRST) && (col_cur >= COL_FIRST);
    at_eol   = (col_cur == COL_LAST);
    at_eof   = at_eol && (row_cur == ROW_LAST);

    col_next = col_reg;
    row_next = row_reg;
    if (accept) begin
      if (at_eol) begin
        col_next = '0;
        row_next = (row_cur == ROW_LAST) ? '0 : row_cur + ROW_W'(1);
      end else begin
        col_next = col_cur + COL_W'(1);
        row_next = row_cur;
      end
    end
  end

  // Window shift: the older columns move toward c=0. The new column comes
  // from the line memories, and data_i goes into the bottom row.
  always_comb begin
    win_next = win_reg;
    for (int r = 0; r < KERNEL_W; r++) begin
      for (int c = 0; c < KERNEL_W - 1; c++) begin
        win_next[r][c] = win_reg[r][c+1];
      end
    end
    for (int r = 0; r < NL; r++) begin
      win_next[r][KERNEL_W-1] = rd_data[r];
    end
    win_next[KERNEL_W-1][KERNEL_W-1] = data_i;
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < KERNEL_W; gi++) begin : g_flat_row
      for (gj = 0; gj < KERNEL_W; gj++) begin : g_flat_col
        assign win_flat[(gi*KERNEL_W+gj)*DATA_W +: DATA_W] = win_next[gi][gj];
      end
    end
  endgenerate

  // Line memories. Each address acts as a vertical shift register of depth NL.
  // Reads are combinational, so in one cycle the old column feeds the window
  // and every memory then takes the value of the next newer memory.
  // The memories are never cleared. Counters restart at row 0 after reset or
  // sof, so NL fresh lines overwrite each column before any window is flagged.
  generate
    for (gi = 0; gi < NL; gi++) begin : g_line
      logic [DATA_W-1:0] mem [IMG_W];
      logic [DATA_W-1:0] wr_data;

      assign rd_data[gi] = mem[col_cur];

      if (gi == NL - 1) begin : g_newest
        assign wr_data = data_i;
      end else begin : g_older
        assign wr_data = rd_data[gi+1];
      end

      always_ff @(posedge clk_i) begin
        if (accept) begin
          mem[col_cur] <= wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      col_reg        <= '0;
      row_reg        <= '0;
      window_o       <= '0;
      window_valid_o <= 1'b0;
      eol_o          <= 1'b0;
      eof_o          <= 1'b0;
      for (int r = 0; r < KERNEL_W; r++) begin
        for (int c = 0; c < KERNEL_W; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else begin
      window_valid_o <= accept && win_done;
      eol_o          <= accept && win_done && at_eol;
      eof_o          <= accept && win_done && at_eof;
      if (accept) begin
        col_reg <= col_next;
        row_reg <= row_next;
        win_reg <= win_next;
      end
      // window_o only changes when a complete window is produced.
      if (accept && win_done) begin
        window_o <= win_flat;
      end
    end
  end

endmodule

// File: doc/kernel_window_buffer.md
KERNEL_WINDOW_BUFFER -- requirements
Module: kernel_window_buffer

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter KERNEL_W, default 3, window side length; legal values are odd and >= 3.
REQ-003 Parameter IMG_W, default 512, pixels per line; IMG_W >= KERNEL_W.
REQ-004 Parameter IMG_H, default 512, lines per frame; IMG_H >= KERNEL_W.
REQ-005 clk_i  input  1  single clock; all logic on rising edge.
REQ-006 srst_i  input  1  reset, synchronous, active-high.
REQ-007 data_i  input  DATA_W  pixel, raster order.
REQ-008 valid_i  input  1  data_i accepted on any edge with valid_i=1; there is no backpressure.
REQ-009 sof_i  input  1  start of frame; qualified by valid_i; marks the pixel at (row 0, col 0).
REQ-010 window_o  output  KERNEL_W*KERNEL_W*DATA_W  window; element (r,c) at bits [(r*KERNEL_W+c)*DATA_W +: DATA_W]; r=0 is the oldest line, c=0 is the oldest column.
REQ-011 window_valid_o  output  1  window_o holds a complete window.
REQ-012 eol_o  output  1  window is the last of its line; asserted only with window_valid_o.
REQ-013 eof_o  output  1  window is the last of the frame; asserted only with window_valid_o.

Function
REQ-014 Storage: KERNEL_W-1 circular line memories, IMG_W deep, DATA_W wide; a KERNEL_W x KERNEL_W register window; a column counter col (0..IMG_W-1); a row counter row (0..IMG_H-1).
REQ-015 On an accepted pixel, the window shifts one column toward c=0.
REQ-016 New column c=KERNEL_W-1 on an accepted pixel: r=KERNEL_W-1 <- data_i; r=0..KERNEL_W-2 <- the line-memory values at address col (lines row-KERNEL_W+1 .. row-1).
REQ-017 The line memories shift vertically at address col in the same cycle: each memory takes the next-newer memory's value; the newest memory takes data_i.
REQ-018 Counters: col increments per accepted pixel; at IMG_W-1 col wraps to 0 and row increments; at (IMG_H-1, IMG_W-1) both wrap to 0 (automatic next frame).
REQ-019 sof_i=1 with valid_i=1 forces that pixel to be treated as (0,0): counters restart from there; the line-memory contents are not cleared.
REQ-020 sof_i with valid_i=0 is ignored.
REQ-021 Valid-only mode, no padding: window_valid_o is asserted the cycle after accepting pixel (row, col) iff row >= KERNEL_W-1 and col >= KERNEL_W-1; that pixel is window element (KERNEL_W-1, KERNEL_W-1).
REQ-022 Window count: each frame yields (IMG_W-KERNEL_W+1)*(IMG_H-KERNEL_W+1) windows.
REQ-023 Latency: exactly 1 cycle from accepted pixel to the registered outputs.
REQ-024 window_valid_o, eol_o and eof_o are single-cycle pulses; they are 0 in any cycle following valid_i=0.
REQ-025 window_o holds its last value when no window is produced.
REQ-026 eol_o=1 when the accepted col = IMG_W-1 (and REQ-021 holds).
REQ-027 eof_o=1 additionally requires row = IMG_H-1.
REQ-028 Gaps in valid_i do not alter the window contents or their order.

Reset
REQ-029 While srst_i=1: col=0; row=0; window registers=0; window_o=0; window_valid_o=0; eol_o=0; eof_o=0.
REQ-030 The line memories need no reset; their stale contents never reach a window flagged valid.
REQ-031 srst_i has priority over valid_i and sof_i.
REQ-032 After reset mid-frame, the next accepted pixel is (0,0).

Verification
All scenarios use KERNEL_W=3, IMG_W=8, IMG_H=4, with pixel value = row*16+col.
REQ-033 Reset held 3 cycles with random valid_i/data_i -> window_o=0, window_valid_o=0, eol_o=0, eof_o=0 throughout.
REQ-034 Continuous ramp frame with sof_i on the first pixel -> first window_valid_o one cycle after pixel 0x22, window r0={00,01,02}, r1={10,11,12}, r2={20,21,22}; exactly 12 windows per frame.
REQ-035 Same frame with valid_i=1 on alternate cycles -> identical window sequence; window_valid_o never asserted after a valid_i=0 cycle.
REQ-036 eol_o pulses with bottom-right pixels 0x27 and 0x37 only; eof_o pulses once, with bottom-right 0x37; back-to-back second frame without sof_i -> same 12 windows.
REQ-037 sof_i reasserted at pixel 0x14 of frame 1 -> counters restart; first window of the new frame appears after the third line's col 2; no window produced from stale row/col.
REQ-038 srst_i pulsed after pixel 0x25, then a full frame -> outputs 0 during reset; subsequent frame matches REQ-034 exactly.
